pe_mem_arbiter: RTL and testbench
=================================

# pe_mem_arbiter

Shares one data-memory port among NUM_PE processing elements in the CGRA array. Each processing element presents its load/store request with its existing mem_read/mem_write/mem_address level handshake. The arbiter grants requests round-robin, runs one memory transaction at a time, and returns a one-cycle mem_ack plus read data to the granted element. It sits between the PE grid and the single shared data SRAM/bus port.

## Interface
- NUM_PE, 4, number of requesting PEs (2..16)
- DATA_W, 32, address and data width
- TIMEOUT, 64, maximum cycles allowed in ISSUE before abort (≥2)
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high; sampled on rising clk
- pe_mem_read  in  NUM_PE  per-PE load request, held until its ack
- pe_mem_write  in  NUM_PE  per-PE store request, held until its ack
- pe_mem_address  in  NUM_PE*DATA_W  per-PE address; PE i occupies bits [i*DATA_W +: DATA_W]
- pe_wdata  in  NUM_PE*DATA_W  per-PE store data, same packing
- pe_mem_ack  out  NUM_PE  one-hot, one-cycle completion pulse
- pe_rdata  out  DATA_W  load data broadcast to all PEs; valid in the ack cycle
- pe_err  out  1  high with ack when the transaction timed out
- mem_req  out  1  request to memory, held until mem_ready or abort
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_ready  in  1  one-cycle completion from memory; mem_rdata valid with it
- mem_rdata  in  DATA_W  load data

## Operation
- All outputs are registered. Reset drives every output to 0, sets the state to IDLE, sets the round-robin pointer to 0, and clears the timeout counter.
- A PE is requesting when pe_mem_read[i] or pe_mem_write[i] is high. If both are high, the arbiter performs a store.
- State IDLE: pick the first requesting PE starting at the pointer, wrapping modulo NUM_PE. Latch that PE's index, mem_we, address and wdata, then go to ISSUE. With no requester, stay in IDLE.
- State ISSUE: mem_req=1. mem_addr, mem_we and mem_wdata stay stable. The counter increments each cycle.
  - When mem_ready is seen, capture mem_rdata (loads only) into pe_rdata and go to ACK.
  - When the counter reaches TIMEOUT-1 without mem_ready, drop mem_req and go to ACK with pe_err=1.
- State ACK: pe_mem_ack[granted]=1 for exactly one cycle and pe_err is valid. The pointer becomes granted+1 mod NUM_PE. The counter clears. Next state is IDLE.
- Masking: the PE just acked is excluded from selection in the IDLE cycle that follows ACK. This covers a PE that drops its request one cycle late, so it gets no double service.
- pe_rdata holds its last captured value until the next load completes. Stores do not update it.
- A request withdrawn mid-transaction still completes, and its ack is still pulsed.
- mem_ready seen outside ISSUE is ignored.
- Reset during ISSUE abandons the transaction: mem_req=0 after that edge, and no ack is issued.

## Timing
- Request sampled in IDLE at edge N: mem_req goes high after edge N+1.
- Zero-wait memory (mem_ready in the first ISSUE cycle): ack after edge N+3. Minimum latency is 3 cycles.
- Memory with k wait cycles: latency is 3+k cycles.
- Throughput: one transaction per 3+k cycles. There is no back-to-back overlap.
- Timeout: ack with pe_err is asserted TIMEOUT+2 cycles after the request is sampled.
- Fairness: with all NUM_PE requesting continuously, each PE is served exactly once per NUM_PE transactions.

## Structure
- Shared header pe_mem_defs.vh holds:
  - state encodings: IDLE=2'd0, ISSUE=2'd1, ACK=2'd2
  - default parameter values
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: request vector, pointer, mask index.
  - Outputs: valid flag and granted index.
  - Reusable by other shared-resource arbiters in the array.
- The top level contains the FSM, the timeout counter, the latches and the output registers.

## Test plan
- Single load: PE2 reads 0x0000_0023 and memory returns 0xFFFF_80A5 with 0 wait. Expect:
  - mem_req for 1 cycle with mem_addr=0x23, mem_we=0
  - pe_mem_ack=4'b0100 three cycles after the request
  - pe_rdata=0xFFFF_80A5
- Round-robin: PE0..3 all request stores with address=i at the same time, pointer=0. Expect grants in order 0,1,2,3, then the pointer wraps to 0.
- Pointer mid-way: pointer=2 with PE1 and PE3 requesting. Expect PE3 first, then PE1.
- Timeout: with TIMEOUT=8 and memory never asserting mem_ready, expect:
  - mem_req for 8 cycles, then 0
  - the ack pulse with pe_err=1
  - pe_rdata unchanged
- Late drop: PE1 holds its request one cycle after its ack while PE0 also requests. Expect PE0 served next, with no second ack to PE1.
- Reset in ISSUE: assert reset during a 5-wait-cycle load. Expect:
  - mem_req=0 and all acks 0 on the next cycle
  - pointer=0
  - a later mem_ready is ignored

Source files
------------

// File: rtl/pe_mem_arbiter_pkg.sv
// Shared definitions for the PE data-memory arbiter: FSM state encodings and
// default parameter values.
package pe_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int DEF_NUM_PE  = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/pe_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after the pointer,
// wrapping, optionally skipping one masked index.
module rr_pick #(
  parameter int NUM_PE = 4,
  parameter int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic [NUM_PE-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              mask_en,
  input  logic [IDX_W-1:0]  mask_idx,
  output logic              vld,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_PE);
      if (!vld && req[cand] && !(mask_en && (cand == mask_idx))) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_PE processing
// elements; one transaction in flight, with timeout abort.
module pe_mem_arbiter
  import pe_mem_arbiter_pkg::*;
#(
  parameter int NUM_PE  = DEF_NUM_PE,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PE-1:0]        pe_mem_read,
  input  logic [NUM_PE-1:0]        pe_mem_write,
  input  logic [NUM_PE*DATA_W-1:0] pe_mem_address,
  input  logic [NUM_PE*DATA_W-1:0] pe_wdata,
  output logic [NUM_PE-1:0]        pe_mem_ack,
  output logic [DATA_W-1:0]        pe_rdata,
  output logic                     pe_err,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] mask_idx;
  logic             mask_vld;
  logic [CNT_W-1:0] cnt;
  logic             err_flag;

  logic [NUM_PE-1:0] req;
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  next_ptr;

  assign req      = pe_mem_read | pe_mem_write;
  assign next_ptr = (grant == IDX_W'(NUM_PE - 1)) ? '0 : grant + 1'b1;

  rr_pick #(.NUM_PE(NUM_PE), .IDX_W(IDX_W)) u_pick (
    .req      (req),
    .ptr      (ptr),
    .mask_en  (mask_vld),
    .mask_idx (mask_idx),
    .vld      (pick_vld),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      grant      <= '0;
      mask_idx   <= '0;
      mask_vld   <= 1'b0;
      cnt        <= '0;
      err_flag   <= 1'b0;
      pe_mem_ack <= '0;
      pe_rdata   <= '0;
      pe_err     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      pe_mem_ack <= '0;
      pe_err     <= 1'b0;
      mask_vld   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant     <= pick_idx;
            mem_we    <= pe_mem_write[pick_idx];
            mem_addr  <= pe_mem_address[int'(pick_idx)*DATA_W +: DATA_W];
            mem_wdata <= pe_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            cnt       <= '0;
            err_flag  <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // First ISSUE cycle only raises mem_req; the counter runs while it is up.
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) pe_rdata <= mem_rdata;
            state <= ACK;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_req  <= 1'b0;
            err_flag <= 1'b1;
            state    <= ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
          pe_mem_ack[grant] <= 1'b1;
          pe_err            <= err_flag;
          ptr               <= next_ptr;
          cnt               <= '0;
          mask_vld          <= 1'b1;
          mask_idx          <= grant;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Directed bench for pe_mem_arbiter: vector table of single transactions plus
// hand sequences for late request drop and reset during ISSUE.
module tb_pe_mem_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    pe_mem_read, pe_mem_write;
  logic [NP*DW-1:0] pe_mem_address, pe_wdata;
  logic [NP-1:0]    pe_mem_ack;
  logic [DW-1:0]    pe_rdata;
  logic             pe_err;
  logic             mem_req, mem_we;
  logic [DW-1:0]    mem_addr, mem_wdata;
  logic             mem_ready;
  logic [DW-1:0]    mem_rdata;

  pe_mem_arbiter #(.NUM_PE(NP), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .pe_mem_read(pe_mem_read), .pe_mem_write(pe_mem_write),
    .pe_mem_address(pe_mem_address), .pe_wdata(pe_wdata),
    .pe_mem_ack(pe_mem_ack), .pe_rdata(pe_rdata), .pe_err(pe_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0]    rd, wr;
    logic [NP*DW-1:0] addr, wdata;
    int               wait_cyc;
    bit               never;
    logic [DW-1:0]    rdata;
    logic [NP-1:0]    exp_ack;
    logic             exp_we;
    logic [DW-1:0]    exp_addr, exp_wdata, exp_rdata;
    logic             exp_err;
    int               exp_lat, exp_req;
  } vec_t;

  typedef struct {
    logic [NP-1:0] ack;
    logic          err;
    logic [DW-1:0] rdata, addr, wdata;
    logic          we;
    int            lat, reqc;
  } res_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[12];

  function automatic logic [NP*DW-1:0] pk(input logic [DW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic [3:0] rd, wr, input logic [127:0] addr, wdata,
                              input int wt, input bit nv, input logic [31:0] rdata,
                              input logic [3:0] eack, input logic ewe,
                              input logic [31:0] eaddr, ewd, erd, input logic eerr,
                              input int elat, ereq);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.wait_cyc = wt; v.never = nv;
    v.rdata = rdata; v.exp_ack = eack; v.exp_we = ewe; v.exp_addr = eaddr;
    v.exp_wdata = ewd; v.exp_rdata = erd; v.exp_err = eerr; v.exp_lat = elat; v.exp_req = ereq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with requests already driven; plays the memory side.
  task automatic run_txn(input int wait_cyc, input bit never, input logic [DW-1:0] rdata,
                         output res_t r);
    bit got = 1'b0;
    r.ack = '0; r.err = 1'b0; r.rdata = '0; r.addr = '0; r.wdata = '0; r.we = 1'b0;
    r.lat = 0; r.reqc = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk);
      r.lat++;
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_req) begin
        if (r.reqc == 0) begin
          r.addr = mem_addr; r.we = mem_we; r.wdata = mem_wdata;
        end
        r.reqc++;
        if (!never && r.reqc == wait_cyc + 1) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
        end
      end
      if (pe_mem_ack != '0) begin
        got = 1'b1;
        r.ack = pe_mem_ack; r.err = pe_err; r.rdata = pe_rdata;
      end
    end
    r.lat = r.lat - 1;
  endtask

  task automatic idle_watch(input string nm, input int cycles);
    int act = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (mem_req || pe_mem_ack != '0) act++;
    end
    chk(nm, 32'(act), 32'd0);
  endtask

  initial begin
    res_t r;
    logic [127:0] a_rr, w_rr, a_ld;
    a_rr = pk(0, 1, 2, 3);
    w_rr = pk(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    a_ld = pk(32'h40, 32'h41, 32'h42, 32'h43);

    vecs[0]  = mk(4'b0100, 4'b0000, pk(32'h10, 32'h11, 32'h23, 32'h13), '0, 0, 0, 32'hFFFF_80A5,
                  4'b0100, 0, 32'h23, 0, 32'hFFFF_80A5, 0, 3, 1);
    vecs[1]  = mk(4'b1000, 4'b0000, pk(32'h10, 32'h11, 32'h23, 32'h33), '0, 2, 0, 32'h1234_5678,
                  4'b1000, 0, 32'h33, 0, 32'h1234_5678, 0, 5, 3);
    vecs[2]  = mk(4'b0000, 4'b1111, a_rr, w_rr, 0, 0, 32'h0, 4'b0001, 1, 0, 32'hA0, 32'h1234_5678, 0, 3, 1);
    vecs[3]  = mk(4'b0000, 4'b1111, a_rr, w_rr, 1, 0, 32'h0, 4'b0010, 1, 1, 32'hA1, 32'h1234_5678, 0, 4, 2);
    vecs[4]  = mk(4'b0000, 4'b1111, a_rr, w_rr, 0, 0, 32'h0, 4'b0100, 1, 2, 32'hA2, 32'h1234_5678, 0, 3, 1);
    vecs[5]  = mk(4'b1000, 4'b1111, a_rr, w_rr, 0, 0, 32'hDEAD_BEEF, 4'b1000, 1, 3, 32'hA3, 32'h1234_5678, 0, 3, 1);
    vecs[6]  = mk(4'b0000, 4'b1111, a_rr, w_rr, 0, 0, 32'h0, 4'b0001, 1, 0, 32'hA0, 32'h1234_5678, 0, 3, 1);
    vecs[7]  = mk(4'b0000, 4'b0010, a_rr, w_rr, 0, 0, 32'h0, 4'b0010, 1, 1, 32'hA1, 32'h1234_5678, 0, 3, 1);
    vecs[8]  = mk(4'b1010, 4'b0000, a_ld, '0, 0, 0, 32'h1111_0003, 4'b1000, 0, 32'h43, 0, 32'h1111_0003, 0, 3, 1);
    vecs[9]  = mk(4'b0010, 4'b0000, a_ld, '0, 1, 0, 32'h5A5A_0001, 4'b0010, 0, 32'h41, 0, 32'h5A5A_0001, 0, 4, 2);
    vecs[10] = mk(4'b0001, 4'b0000, pk(32'h50, 32'h51, 32'h52, 32'h53), '0, 0, 1, 32'h7777_7777,
                  4'b0001, 0, 32'h50, 0, 32'h5A5A_0001, 1, TO + 2, TO);
    vecs[11] = mk(4'b0100, 4'b0000, pk(32'h60, 32'h61, 32'h62, 32'h63), '0, 3, 0, 32'hC0DE_0042,
                  4'b0100, 0, 32'h62, 0, 32'hC0DE_0042, 0, 6, 4);

    reset = 1'b1;
    pe_mem_read = '0; pe_mem_write = '0; pe_mem_address = '0; pe_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset mem_req/we", 32'({mem_req, mem_we}), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset ack/err", 32'({pe_mem_ack, pe_err}), 32'd0);
    chk("reset pe_rdata", pe_rdata, 32'd0);

    for (int i = 0; i < 12; i++) begin
      pe_mem_read = vecs[i].rd; pe_mem_write = vecs[i].wr;
      pe_mem_address = vecs[i].addr; pe_wdata = vecs[i].wdata;
      run_txn(vecs[i].wait_cyc, vecs[i].never, vecs[i].rdata, r);
      chk($sformatf("v%0d ack", i), 32'(r.ack), 32'(vecs[i].exp_ack));
      chk($sformatf("v%0d we", i), 32'(r.we), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d addr", i), r.addr, vecs[i].exp_addr);
      chk($sformatf("v%0d wdata", i), r.wdata, vecs[i].exp_wdata);
      chk($sformatf("v%0d rdata", i), r.rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d err", i), 32'(r.err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d latency", i), 32'(r.lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d req cycles", i), 32'(r.reqc), 32'(vecs[i].exp_req));
    end

    // Late drop: PE1 acked, keeps requesting one more cycle while PE0 arrives.
    pe_mem_address = pk(32'h70, 32'h71, 32'h72, 32'h73); pe_wdata = '0;
    pe_mem_write = '0; pe_mem_read = 4'b0010;
    run_txn(0, 0, 32'h0000_7171, r);
    chk("late PE1 ack", 32'(r.ack), 32'b0010);
    pe_mem_read = 4'b0011;
    @(posedge clk); @(negedge clk);
    pe_mem_read = 4'b0001;
    run_txn(0, 0, 32'h0000_7070, r);
    chk("late PE0 ack", 32'(r.ack), 32'b0001);
    chk("late PE0 addr", r.addr, 32'h70);
    chk("late PE0 lat", 32'(r.lat), 32'd2);
    pe_mem_read = '0;
    idle_watch("late no second ack", 10);

    // Sole requester holding one cycle past its ack must not be re-served.
    pe_mem_read = 4'b0100;
    run_txn(0, 0, 32'h2222_0000, r);
    chk("hold PE2 ack", 32'(r.ack), 32'b0100);
    @(posedge clk); @(negedge clk);
    pe_mem_read = '0;
    idle_watch("hold masked", 10);

    // Reset during a 5-wait load; the pointer is 3 going in.
    pe_mem_read = 4'b0010;
    begin
      int n = 0;
      while (!mem_req && n < 10) begin
        @(posedge clk); @(negedge clk); n++;
      end
      chk("rst mem_req seen", 32'(mem_req), 32'd1);
    end
    repeat (2) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1; pe_mem_read = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst ack", 32'(pe_mem_ack), 32'd0);
    chk("rst pe_rdata", pe_rdata, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hFACE_0001;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    idle_watch("rst late ready ignored", 6);
    chk("rst rdata after ready", pe_rdata, 32'd0);
    pe_mem_read = 4'b1100;
    run_txn(0, 0, 32'h3333_0002, r);
    chk("rst ptr=0 ack", 32'(r.ack), 32'b0100);
    chk("rst ptr=0 addr", r.addr, 32'h72);
    pe_mem_read = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
